// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared types for the dispatch scheduler: station classes and FSM states.
// Supplies a default ROB tag width when the build does not define one.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

package rs_dispatch_scheduler_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_MEM  = 2'd1,
        CLS_BR   = 2'd2,
        CLS_NONE = 2'd3
    } disp_class_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } disp_state_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rs_credit_counter.sv
// Per-station credit counter: one credit per free reservation station entry.
// Reload wins, then a simultaneous take/return nets to zero; returns saturate.
module rs_credit_counter #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          inc,
    input  logic          reload,
    output logic [CW-1:0] count,
    output logic          has_credit
);

    // Track free entries; a return at full depth is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CW'(DEPTH);
        end else if (reload) begin
            count <= CW'(DEPTH);
        end else if (dec && !inc) begin
            count <= count - CW'(1);
        end else if (inc && !dec && (count != CW'(DEPTH))) begin
            count <= count + CW'(1);
        end
    end

    assign has_credit = (count != '0);

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Routes renamed instructions to ALU/MEM/BRANCH stations through a skid buffer.
// Optional DISPATCH_PERF_CNT_EN adds stall-cycle and dispatch counters.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

module rs_dispatch_scheduler
    import rs_dispatch_scheduler_pkg::*;
#(
    parameter int ALU_RS_DEPTH = 8,
    parameter int MEM_RS_DEPTH = 4,
    parameter int BR_RS_DEPTH  = 4,
    parameter int TAG_WIDTH    = `ROB_SIZE_WIDTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  disp_class_t          in_class,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 rob_full,
    input  logic                 flush,
    input  logic                 alu_credit_ret,
    input  logic                 mem_credit_ret,
    input  logic                 br_credit_ret,
    output logic                 alu_disp_valid,
    output logic                 mem_disp_valid,
    output logic                 br_disp_valid,
    output logic [TAG_WIDTH-1:0] disp_tag,
    output logic                 stall_out,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [31:0]          stall_cycle_cnt,
    output logic [31:0]          dispatch_cnt,
`endif
    output logic                 in_recovery
);

    localparam int ALU_CW = credit_width(ALU_RS_DEPTH);
    localparam int MEM_CW = credit_width(MEM_RS_DEPTH);
    localparam int BR_CW  = credit_width(BR_RS_DEPTH);
    localparam int FCW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    disp_state_t          state;
    logic [FCW-1:0]       flush_cnt;
    logic                 hold_valid;
    disp_class_t          hold_class;
    logic [TAG_WIDTH-1:0] hold_tag;

    logic                 accept;
    logic                 pend_valid;
    logic                 pend_nop;
    disp_class_t          pend_class;
    logic [TAG_WIDTH-1:0] pend_tag;
    logic                 credit_ok;
    logic                 dispatch;
    logic                 ret_en;
    logic                 alu_dec, mem_dec, br_dec;
    logic                 alu_ok, mem_ok, br_ok;
    logic [ALU_CW-1:0]    alu_count;
    logic [MEM_CW-1:0]    mem_count;
    logic [BR_CW-1:0]     br_count;

    assign stall_out   = hold_valid | (state == FLUSH);
    assign in_recovery = (state == FLUSH);
    assign accept      = in_valid & ~stall_out;
    assign pend_valid  = hold_valid | accept;
    assign pend_class  = hold_valid ? hold_class : in_class;
    assign pend_tag    = hold_valid ? hold_tag : in_tag;
    assign pend_nop    = (pend_class == CLS_NONE);

    // Select the registered credit state of the pending item's station.
    always_comb begin
        credit_ok = 1'b0;
        unique case (pend_class)
            CLS_ALU: credit_ok = alu_ok;
            CLS_MEM: credit_ok = mem_ok;
            CLS_BR:  credit_ok = br_ok;
            default: credit_ok = 1'b0;
        endcase
    end

    assign dispatch = pend_valid & ~pend_nop & credit_ok & ~rob_full & ~flush;
    assign alu_dec  = dispatch & (pend_class == CLS_ALU);
    assign mem_dec  = dispatch & (pend_class == CLS_MEM);
    assign br_dec   = dispatch & (pend_class == CLS_BR);
    assign ret_en   = (state == RUN) & ~flush;

    rs_credit_counter #(.DEPTH(ALU_RS_DEPTH)) u_alu_credit (
        .clk(clk), .reset(reset), .dec(alu_dec),
        .inc(alu_credit_ret & ret_en), .reload(flush),
        .count(alu_count), .has_credit(alu_ok)
    );

    rs_credit_counter #(.DEPTH(MEM_RS_DEPTH)) u_mem_credit (
        .clk(clk), .reset(reset), .dec(mem_dec),
        .inc(mem_credit_ret & ret_en), .reload(flush),
        .count(mem_count), .has_credit(mem_ok)
    );

    rs_credit_counter #(.DEPTH(BR_RS_DEPTH)) u_br_credit (
        .clk(clk), .reset(reset), .dec(br_dec),
        .inc(br_credit_ret & ret_en), .reload(flush),
        .count(br_count), .has_credit(br_ok)
    );

    // Skid buffer: park an accepted item that could not leave this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_class <= CLS_NONE;
            hold_tag   <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else begin
            hold_valid <= pend_valid & ~pend_nop & ~dispatch;
            if (accept) begin
                hold_class <= in_class;
                hold_tag   <= in_tag;
            end
        end
    end

    // Registered one-hot dispatch strobe and its tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_disp_valid <= 1'b0;
            mem_disp_valid <= 1'b0;
            br_disp_valid  <= 1'b0;
            disp_tag       <= '0;
        end else begin
            alu_disp_valid <= alu_dec;
            mem_disp_valid <= mem_dec;
            br_disp_valid  <= br_dec;
            if (dispatch) begin
                disp_tag <= pend_tag;
            end
        end
    end

    // Flush recovery: a flush always (re)starts the countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else if (flush) begin
            state     <= FLUSH;
            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            if (flush_cnt == '0) begin
                state <= RUN;
            end else begin
                flush_cnt <= flush_cnt - FCW'(1);
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    // Free-running performance counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycle_cnt <= '0;
            dispatch_cnt    <= '0;
        end else begin
            stall_cycle_cnt <= stall_cycle_cnt + 32'(in_valid & stall_out);
            dispatch_cnt    <= dispatch_cnt + 32'(dispatch);
        end
    end
`endif

    a_alu_bound: assert property (@(posedge clk) disable iff (reset)
        alu_count <= ALU_CW'(ALU_RS_DEPTH));
    a_mem_bound: assert property (@(posedge clk) disable iff (reset)
        mem_count <= MEM_CW'(MEM_RS_DEPTH));
    a_br_bound: assert property (@(posedge clk) disable iff (reset)
        br_count <= BR_CW'(BR_RS_DEPTH));

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Self-checking bench for rs_dispatch_scheduler: vector table plus scoreboard.
// Directed sequences cover flush recovery, credit corners and async reset.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

module tb_rs_dispatch_scheduler;
    import rs_dispatch_scheduler_pkg::*;

    localparam int TW = `ROB_SIZE_WIDTH;
    localparam int S_NO  = 0;
    localparam int S_BR  = 1;
    localparam int S_MEM = 2;
    localparam int S_ALU = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    disp_class_t   in_class;
    logic [TW-1:0] in_tag;
    logic          rob_full, flush;
    logic          alu_credit_ret, mem_credit_ret, br_credit_ret;
    logic          alu_disp_valid, mem_disp_valid, br_disp_valid;
    logic [TW-1:0] disp_tag;
    logic          stall_out, in_recovery;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0]   stall_cycle_cnt, dispatch_cnt;
`endif

    rs_dispatch_scheduler dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_class(in_class), .in_tag(in_tag),
        .rob_full(rob_full), .flush(flush),
        .alu_credit_ret(alu_credit_ret),
        .mem_credit_ret(mem_credit_ret),
        .br_credit_ret(br_credit_ret),
        .alu_disp_valid(alu_disp_valid),
        .mem_disp_valid(mem_disp_valid),
        .br_disp_valid(br_disp_valid),
        .disp_tag(disp_tag), .stall_out(stall_out),
`ifdef DISPATCH_PERF_CNT_EN
        .stall_cycle_cnt(stall_cycle_cnt),
        .dispatch_cnt(dispatch_cnt),
`endif
        .in_recovery(in_recovery)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        disp_class_t   c;
        logic [TW-1:0] t;
        logic          rf, ar, mr, br;
        logic          e_stall;
        logic [2:0]    e_strb;
        logic [TW-1:0] e_tag;
    } vec_t;

    typedef struct {
        logic [2:0]    strb;
        logic [TW-1:0] tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] mon_s;
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input int v, input disp_class_t c, input int t,
                       input int rf, input int ar, input int mr, input int br,
                       input int es, input int estr, input int etag);
        vec_t x;
        x.v = (v != 0); x.c = c; x.t = TW'(t);
        x.rf = (rf != 0); x.ar = (ar != 0);
        x.mr = (mr != 0); x.br = (br != 0);
        x.e_stall = (es != 0); x.e_strb = 3'(estr); x.e_tag = TW'(etag);
        tbl.push_back(x);
    endtask

    task automatic set_in(input int v, input disp_class_t c, input int t,
                          input int rf, input int fl, input int ar,
                          input int mr, input int br);
        in_valid = (v != 0); in_class = c; in_tag = TW'(t);
        rob_full = (rf != 0); flush = (fl != 0);
        alu_credit_ret = (ar != 0); mem_credit_ret = (mr != 0);
        br_credit_ret = (br != 0);
    endtask

    task automatic idle();
        set_in(0, CLS_NONE, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_disp(input int s, input int t);
        exp_t e;
        e.strb = 3'(s); e.tag = TW'(t);
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_credits(input string nm, input int a, input int m,
                               input int b);
        chk({nm, "_alu_cr"}, 32'(dut.u_alu_credit.count), 32'(a));
        chk({nm, "_mem_cr"}, 32'(dut.u_mem_credit.count), 32'(m));
        chk({nm, "_br_cr"}, 32'(dut.u_br_credit.count), 32'(b));
    endtask

    function automatic logic [31:0] strobes();
        return 32'({alu_disp_valid, mem_disp_valid, br_disp_valid});
    endfunction

    // Scoreboard: every strobe seen must match the oldest expected dispatch.
    always @(negedge clk) begin
        if (!reset) begin
            mon_s = {alu_disp_valid, mem_disp_valid, br_disp_valid};
            if (mon_s != 3'b000) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: strobes %b tag %0d, expected none",
                             mon_s, disp_tag);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_strobe", 32'(mon_s), 32'(mon_e.strb));
                    chk("sb_tag", 32'(disp_tag), 32'(mon_e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // v c tag rf ar mr br | stall strobe tag
        add(1, CLS_MEM,  1, 0, 0, 0, 0, 0, S_MEM, 1);
        add(1, CLS_MEM,  2, 0, 0, 0, 0, 0, S_MEM, 2);
        add(1, CLS_MEM,  3, 0, 0, 0, 0, 0, S_MEM, 3);
        add(1, CLS_MEM,  4, 0, 0, 0, 0, 0, S_MEM, 4);
        add(1, CLS_MEM,  5, 0, 0, 0, 0, 0, S_NO,  0);
        add(1, CLS_MEM,  6, 0, 0, 0, 0, 1, S_NO,  0);
        add(0, CLS_NONE, 0, 0, 0, 1, 0, 1, S_NO,  0);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 1, S_MEM, 5);
        add(1, CLS_ALU,  5, 0, 0, 0, 0, 0, S_ALU, 5);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 0, S_NO,  0);
        add(1, CLS_NONE, 7, 0, 0, 0, 0, 0, S_NO,  0);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 0, S_NO,  0);
        add(1, CLS_BR,   9, 0, 0, 0, 0, 0, S_BR,  9);
        add(1, CLS_ALU, 10, 0, 0, 0, 1, 0, S_ALU, 10);
        add(1, CLS_ALU, 11, 1, 0, 0, 0, 0, S_NO,  0);
        add(0, CLS_NONE, 0, 1, 0, 0, 0, 1, S_NO,  0);
        add(0, CLS_NONE, 0, 1, 0, 0, 0, 1, S_NO,  0);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 1, S_ALU, 11);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 0, S_NO,  0);
        add(1, CLS_MEM, 12, 0, 0, 1, 0, 0, S_NO,  0);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 1, S_MEM, 12);
        add(0, CLS_NONE, 0, 0, 0, 0, 0, 0, S_NO,  0);

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_tag", 32'(disp_tag), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_recovery", 32'(in_recovery), 32'd0);
        chk_credits("rst", 8, 4, 4);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(32'(tbl[i].v), tbl[i].c, 32'(tbl[i].t), 32'(tbl[i].rf),
                   0, 32'(tbl[i].ar), 32'(tbl[i].mr), 32'(tbl[i].br));
            if (tbl[i].e_strb != 3'b000)
                expect_disp(32'(tbl[i].e_strb), 32'(tbl[i].e_tag));
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall_out),
                32'(tbl[i].e_stall));
            cyc();
            chk($sformatf("v%0d_strobe", i), strobes(), 32'(tbl[i].e_strb));
            if (tbl[i].e_strb != 3'b000)
                chk($sformatf("v%0d_tag", i), 32'(disp_tag),
                    32'(tbl[i].e_tag));
        end
        idle();
        cyc();

        // Flush while an item sits in the skid buffer.
        set_in(1, CLS_ALU, 20, 1, 0, 0, 0, 0);
        cyc();
        chk("fh_held_stall", 32'(stall_out), 32'd1);
        set_in(0, CLS_NONE, 0, 0, 1, 0, 0, 0);
        cyc();
        chk("fh_rec0", 32'(in_recovery), 32'd1);
        chk("fh_strobe0", strobes(), 32'd0);
        chk_credits("fh", 8, 4, 4);
        idle();
        cyc();
        chk("fh_rec1", 32'(in_recovery), 32'd1);
        cyc();
        chk("fh_rec2", 32'(in_recovery), 32'd0);
        chk("fh_stall2", 32'(stall_out), 32'd0);
        set_in(1, CLS_ALU, 21, 0, 0, 0, 0, 0);
        expect_disp(S_ALU, 21);
        cyc();
        chk("fh_new_strobe", strobes(), 32'(S_ALU));
        chk("fh_new_tag", 32'(disp_tag), 32'd21);
        idle();

        // Returns saturate at depth; NOP leaves everything alone.
        alu_credit_ret = 1'b1;
        cyc();
        chk_credits("ret7", 8, 4, 4);
        cyc();
        chk_credits("ret8", 8, 4, 4);
        set_in(1, CLS_NONE, 3, 0, 0, 0, 0, 0);
        #1;
        chk("nop_stall", 32'(stall_out), 32'd0);
        cyc();
        idle();
        chk("nop_strobe", strobes(), 32'd0);
        chk("nop_stall_after", 32'(stall_out), 32'd0);
        chk_credits("nop", 8, 4, 4);

        // BR credit at 1 with a take and return in the same cycle.
        for (int k = 0; k < 3; k++) begin
            set_in(1, CLS_BR, 30 + k, 0, 0, 0, 0, 0);
            expect_disp(S_BR, 30 + k);
            cyc();
        end
        chk("br_cr_one", 32'(dut.u_br_credit.count), 32'd1);
        set_in(1, CLS_BR, 33, 0, 0, 0, 0, 1);
        expect_disp(S_BR, 33);
        cyc();
        chk("br_cr_kept", 32'(dut.u_br_credit.count), 32'd1);
        set_in(1, CLS_BR, 34, 0, 0, 0, 0, 0);
        expect_disp(S_BR, 34);
        cyc();
        chk("br_next_strobe", strobes(), 32'(S_BR));
        chk("br_next_tag", 32'(disp_tag), 32'd34);
        chk("br_cr_zero", 32'(dut.u_br_credit.count), 32'd0);
        idle();
        cyc();

        // Flush beats a dispatchable input, and a re-flush restarts recovery.
        set_in(1, CLS_ALU, 40, 0, 1, 0, 0, 1);
        cyc();
        chk("ff_rec0", 32'(in_recovery), 32'd1);
        chk("ff_strobe", strobes(), 32'd0);
        chk("ff_br_reload", 32'(dut.u_br_credit.count), 32'd4);
        flush = 1'b0;
        #1;
        chk("ff_stall", 32'(stall_out), 32'd1);
        cyc();
        chk("ff_rec1", 32'(in_recovery), 32'd1);
        flush = 1'b1;
        cyc();
        chk("ff_restart", 32'(in_recovery), 32'd1);
        idle();
        cyc();
        chk("ff_rec3", 32'(in_recovery), 32'd1);
        cyc();
        chk("ff_done", 32'(in_recovery), 32'd0);

        // Asynchronous reset drops a held item mid-cycle.
        set_in(1, CLS_MEM, 50, 1, 0, 0, 0, 0);
        cyc();
        chk("rr_held", 32'(stall_out), 32'd1);
        idle();
        rob_full = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rr_stall", 32'(stall_out), 32'd0);
        chk("rr_tag", 32'(disp_tag), 32'd0);
        chk_credits("rr", 8, 4, 4);
        rob_full = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        chk("rr_no_strobe", strobes(), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_scheduler.md
Name: rs_dispatch_scheduler

Overview:
Sits between the decode/rename stage and the three reservation stations (ALU, MEM, BRANCH). It routes each renamed instruction to its target station, using per-station credit counters. It stalls the decode stage when the target station or the ROB is full, and runs a bounded flush recovery sequence. Decoded instructions are held in a one-entry skid buffer so none is lost under backpressure.

Parameters:
ALU_RS_DEPTH, 8, ALU reservation station entries (initial ALU credits)
MEM_RS_DEPTH, 4, MEM reservation station entries
BR_RS_DEPTH, 4, BRANCH reservation station entries
TAG_WIDTH, `ROB_SIZE_WIDTH, ROB tag width
FLUSH_CYCLES, 2, recovery cycles after a flush (minimum 1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decoded instruction valid this cycle
in_class  input  2  disp_class_t: target station of the instruction
in_tag  input  TAG_WIDTH  ROB tag of the instruction
rob_full  input  1  ROB cannot accept an instruction
flush  input  1  pipeline flush
alu_credit_ret  input  1  ALU station freed one entry
mem_credit_ret  input  1  MEM station freed one entry
br_credit_ret  input  1  BRANCH station freed one entry
alu_disp_valid  output  1  registered dispatch strobe to the ALU station
mem_disp_valid  output  1  registered dispatch strobe to the MEM station
br_disp_valid  output  1  registered dispatch strobe to the BRANCH station
disp_tag  output  TAG_WIDTH  tag that goes with the dispatch strobe
stall_out  output  1  back-pressure to decode (combinational)
in_recovery  output  1  high while state is FLUSH

Behaviour:
- Clocking and reset: clk; reset is asynchronous, active-high.
- Reset values: all disp_valid = 0, disp_tag = 0, hold_valid = 0, state = RUN, credits = respective DEPTH, in_recovery = 0.
- stall_out = hold_valid | (state == FLUSH).
- Acceptance: an input is accepted when in_valid & ~stall_out.
- Pending item: the held item if hold_valid, otherwise the accepted input.
- Dispatch condition: pending valid, class != CLS_NONE, credit[class] > 0 (current registered value, no same-cycle bypass of returns), ~rob_full, ~flush.
- On dispatch: the matching disp_valid = 1 and disp_tag = pending tag on the next edge (latency 1 cycle). At most one dispatch per cycle.
- CLS_NONE (NOP) items are consumed silently: no strobe, no credit use.
- Skid buffer:
  - If an accepted input cannot dispatch, it loads the hold buffer.
  - A held item retries every cycle; hold_valid clears on dispatch.
- Credits: next = cur − dispatch + ret, per station.
  - Simultaneous dispatch and return leaves the count unchanged.
  - A return when the count is already at DEPTH is ignored (saturate).
- States:
  - RUN: normal operation, as above.
  - FLUSH: entered on flush=1 in any state.
- Flush:
  - Same edge: hold_valid = 0, all disp_valid = 0, credits reload to DEPTH, counter = FLUSH_CYCLES − 1.
  - During FLUSH, returns and inputs are ignored.
  - Counter decrements each cycle; at 0, go to RUN on the next edge.
  - A flush during FLUSH restarts the counter.
- Flush has priority over every other event in the same cycle.
- Reset mid-operation: immediate return to reset values; an in-flight held item is dropped.

Optional Feature:
Macro DISPATCH_PERF_CNT_EN.
- Defined: adds output stall_cycle_cnt [31:0] and output dispatch_cnt [31:0].
  - stall_cycle_cnt counts cycles with in_valid & stall_out.
  - dispatch_cnt counts dispatches.
  - Both reset to 0, cleared by reset only (not by flush), and wrap modulo 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package: typedef enum logic[1:0] disp_class_t {CLS_ALU=0, CLS_MEM=1, CLS_BR=2, CLS_NONE=3}; typedef enum logic disp_state_t {RUN, FLUSH}.
- Sub-module rs_credit_counter (parameter DEPTH; inputs dec, inc, reload; output count, has_credit), instantiated three times.

Test Plan:
- Credit exhaustion: MEM_RS_DEPTH=4, six back-to-back MEM inputs, no returns -> 4 mem_disp_valid pulses. The 5th input is held, stall_out=1, the 6th is not accepted. One mem_credit_ret -> 5th dispatches the next cycle and stall_out drops.
- Dispatch latency: ALU input with tag 5 at cycle N, credits available -> alu_disp_valid=1 and disp_tag=5 at cycle N+1 only.
- Simultaneous dispatch and return: BR credit=1, BR dispatch and br_credit_ret in the same cycle -> credit stays 1 and the next BR dispatches immediately.
- ROB full: rob_full=1 for 3 cycles with an ALU input -> item held, no strobes. On rob_full=0 -> dispatch the next cycle.
- Flush with a held item: hold_valid=1 and flush pulse -> hold cleared and in_recovery=1 for 2 cycles (FLUSH_CYCLES=2). Credits read 8/4/4, then RUN accepts a new input.
- Overflow return and NOP: ALU at 8 credits with alu_credit_ret -> credit stays 8. CLS_NONE input -> no strobe, credits unchanged, no stall.
